mdio_responder: RTL and testbench
=================================

Name: mdio_responder

Overview:
- PHY-side end of the MDIO management link: the responder that answers frames issued by the station-management controller (mdioControl).
- Oversamples MDC and MDIO on the system clock and decodes IEEE 802.3 clause-22 frames.
- On a read, it drives turnaround and 16 data bits onto MDIO. On a write, it captures 16 data bits.
- Register storage is external, reached through a simple address/strobe interface, so the block can emulate a PHY in simulation or on-board loopback.

Parameters:
- PHY_ADDR, 5'd1: PHY address this responder answers to.
- PREAMBLE_MIN, 32: consecutive 1-bits required before a start sequence is accepted.
- TIMEOUT, 1000: CLK cycles without an MDC rising edge, mid-frame, before the frame is abandoned.

Ports:
- CLK  in  1: system clock. All logic is on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- MDC  in  1: management clock from the controller. Asynchronous to CLK.
- MDIO  inout  1: management data. Driven only while the output enable (oe) is high, otherwise high-Z. Pulled up externally.
- reg_addr  out  5: register address of the current frame.
- reg_re  out  1: one-CLK read strobe.
- reg_rdata  in  16: read data. Valid the CLK cycle after reg_re.
- reg_we  out  1: one-CLK write strobe.
- reg_wdata  out  16: write data. Valid while reg_we is high and held afterwards.
- busy  out  1: high from the accepted start sequence until return to HUNT.
- frame_err  out  1: one-CLK pulse on a malformed frame.

Behaviour:
- Reset (async): state HUNT, preamble count 0, oe=0 (MDIO high-Z). reg_addr=0, reg_wdata=0, reg_re=0, reg_we=0, busy=0, frame_err=0.
- Input sampling:
  - MDC and MDIO each pass through 2-flop synchronizers.
  - mdc_rise = synced MDC is 1 and its previous value was 0.
  - All bit sampling and all MDIO output changes occur only in the CLK cycle of mdc_rise.
- HUNT:
  - A sampled 1 increments the preamble count, saturating at PREAMBLE_MIN.
  - A sampled 0 with count==PREAMBLE_MIN is ST bit 0: go to ST1. A sampled 0 with count below PREAMBLE_MIN clears the count.
- ST1: a sample of 1 goes to OP and asserts busy. A sample of 0 pulses frame_err and returns to HUNT with count 0.
- OP (2 bits): 10 = read, 01 = write. 00 or 11 pulses frame_err and returns to HUNT.
- PHYAD (5 bits, MSB first), then REGAD (5 bits, MSB first).
- After the last REGAD bit:
  - PHYAD != PHY_ADDR: return to HUNT. No strobes, no error, MDIO never driven.
  - Match: reg_addr is loaded that cycle.
  - Read: reg_re pulses the next CLK cycle, and reg_rdata is captured into the shift register the cycle after that.
- Read timing (edge k = the last REGAD sample):
  - Edge k+1 (first TA bit): controller samples Z. After detecting it, set oe=1 and drive 0.
  - After edge k+2: drive data[15]. After each following edge, drive the next bit, down to data[0] after edge k+17.
  - After edge k+18: oe=0, return to HUNT.
- Write: TA bits are sampled and not checked, then 16 data bits MSB first. On the 16th bit, reg_wdata is loaded and reg_we pulses in the following CLK cycle. Then return to HUNT.
- busy falls in the same cycle the state returns to HUNT.
- Timeout:
  - Outside HUNT, a counter increments every CLK and clears on each mdc_rise.
  - On reaching TIMEOUT: oe=0, frame_err pulse, return to HUNT with count 0.
- No strobe is ever issued for an abandoned or reset-interrupted frame.
- Reset mid-read releases MDIO immediately (asynchronous).
- Back-to-back frames: the preamble count restarts from 0 in HUNT. A frame with PREAMBLE_MIN ones after the previous frame end is accepted.

Test Plan:
- Read: 32 ones, ST=01, OP=10, PHYAD=1, REGAD=2, reg_rdata=16'hA5C3, MDC period 400 ns.
  -> reg_re single pulse with reg_addr=2. MDIO is Z at TA1, 0 at TA2, then 1010010111000011 on 16 successive rising edges, Z afterwards. busy high for the frame.
- Write: PHYAD=1, REGAD=3, data 16'h1234.
  -> exactly one reg_we pulse with reg_addr=3 and reg_wdata=16'h1234. MDIO never driven. reg_re stays 0.
- Address filter: read frame with PHYAD=5.
  -> no reg_re or reg_we, MDIO stays Z, frame_err stays 0. The next valid frame is answered normally.
- Malformed: 31-one preamble then 01 -> ignored, no busy. Valid preamble with OP=11 -> one frame_err pulse, busy low after it, no strobes.
- Reset/stall:
  - reset asserted at data bit 8 of a read -> MDIO Z in the same cycle, all outputs 0.
  - MDC frozen for 1000 CLK cycles mid-write -> frame_err pulse, no reg_we, busy 0.
  - A following valid read succeeds.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side). MDC/MDIO are oversampled on clk_i, frames are
// decoded bit by bit, and reads/writes are bridged to an external register strobe port.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         TIMEOUT      = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mdc_i,
    inout  wire         mdio_io,
    output logic [4:0]  reg_addr_o,
    output logic        reg_re_o,
    input  logic [15:0] reg_rdata_i,
    output logic        reg_we_o,
    output logic [15:0] reg_wdata_o,
    output logic        busy_o,
    output logic        frame_err_o
);

    localparam int PRE_W = $clog2(PREAMBLE_MIN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_MIN);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        HUNT,
        ST1,
        OP,
        PHYAD,
        REGAD,
        TA,
        RDATA,
        WDATA
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              op0_q, op0_d;
    logic              rd_q, rd_d;
    logic [4:0]        phy_q, phy_d;
    logic [3:0]        regad_q, regad_d;
    logic [15:0]       sh_q, sh_d;
    logic              oe_q, oe_d;
    logic              mdo_q, mdo_d;
    logic [4:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              re_q, re_d;
    logic              re_dly_q;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [2:0]        mdc_sync_q;
    logic [1:0]        mdio_sync_q;

    logic              mdc_rise;
    logic              bit_s;

    // Bit [2] of the MDC chain is the previous synchronized value, used for edge detection.
    assign mdc_rise = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign bit_s    = mdio_sync_q[1];

    assign mdio_io     = oe_q ? mdo_q : 1'bz;
    assign reg_addr_o  = addr_q;
    assign reg_re_o    = re_q;
    assign reg_we_o    = we_q;
    assign reg_wdata_o = wdata_q;
    assign busy_o      = busy_q;
    assign frame_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= HUNT;
            pre_q       <= '0;
            to_q        <= '0;
            cnt_q       <= '0;
            op0_q       <= 1'b0;
            rd_q        <= 1'b0;
            phy_q       <= '0;
            regad_q     <= '0;
            sh_q        <= '0;
            oe_q        <= 1'b0;
            mdo_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            re_q        <= 1'b0;
            re_dly_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            op0_q       <= op0_d;
            rd_q        <= rd_d;
            phy_q       <= phy_d;
            regad_q     <= regad_d;
            sh_q        <= sh_d;
            oe_q        <= oe_d;
            mdo_q       <= mdo_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            re_q        <= re_d;
            re_dly_q    <= re_q;
            we_q        <= we_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mdc_sync_q  <= {mdc_sync_q[1:0], mdc_i};
            mdio_sync_q <= {mdio_sync_q[0], mdio_io};
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        op0_d   = op0_q;
        rd_d    = rd_q;
        phy_d   = phy_q;
        regad_d = regad_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        mdo_d   = mdo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b0;

        // Read data from the register port is valid one cycle after the strobe.
        if (re_dly_q) begin
            sh_d = reg_rdata_i;
        end

        if (state_q == HUNT || mdc_rise) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end

        if (state_q != HUNT && !mdc_rise && to_q == TO_LAST) begin
            state_d = HUNT;
            oe_d    = 1'b0;
            err_d   = 1'b1;
            pre_d   = '0;
        end else if (mdc_rise) begin
            case (state_q)
                HUNT: begin
                    if (bit_s) begin
                        if (pre_q != PRE_FULL) begin
                            pre_d = pre_q + 1'b1;
                        end
                    end else if (pre_q == PRE_FULL) begin
                        state_d = ST1;
                        pre_d   = '0;
                    end else begin
                        pre_d = '0;
                    end
                end
                ST1: begin
                    if (bit_s) begin
                        state_d = OP;
                        cnt_d   = '0;
                    end else begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end
                end
                OP: begin
                    if (cnt_q == 5'd0) begin
                        op0_d = bit_s;
                        cnt_d = 5'd1;
                    end else if (op0_q != bit_s) begin
                        rd_d    = op0_q;
                        state_d = PHYAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end
                end
                PHYAD: begin
                    phy_d = {phy_q[3:0], bit_s};
                    if (cnt_q == 5'd4) begin
                        state_d = REGAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                REGAD: begin
                    if (cnt_q != 5'd4) begin
                        regad_d = {regad_q[2:0], bit_s};
                        cnt_d   = cnt_q + 5'd1;
                    end else if (phy_q == PHY_ADDR) begin
                        addr_d  = {regad_q, bit_s};
                        re_d    = rd_q;
                        state_d = TA;
                        cnt_d   = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                TA: begin
                    // Reads take the bus after the controller's Z bit; writes just skip two bits.
                    if (rd_q) begin
                        oe_d    = 1'b1;
                        mdo_d   = 1'b0;
                        state_d = RDATA;
                        cnt_d   = '0;
                    end else if (cnt_q == 5'd0) begin
                        cnt_d = 5'd1;
                    end else begin
                        state_d = WDATA;
                        cnt_d   = '0;
                    end
                end
                RDATA: begin
                    if (cnt_q == 5'd16) begin
                        oe_d    = 1'b0;
                        state_d = HUNT;
                    end else begin
                        mdo_d = sh_q[15];
                        sh_d  = {sh_q[14:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                WDATA: begin
                    sh_d = {sh_q[14:0], bit_s};
                    if (cnt_q == 5'd15) begin
                        wdata_d = {sh_q[14:0], bit_s};
                        we_d    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        busy_d = !(state_d == HUNT || state_d == ST1);
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: acts as MDIO controller plus external register file, and
// checks strobes, error pulses, busy and the read data seen on the wire.
module tb_mdio_responder;

    localparam logic [4:0] PHY     = 5'd1;
    localparam int         PRE_MIN = 32;

    typedef struct {
        int          preLen;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        int          expRe;
        int          expWe;
        int          expErr;
        logic        expBusy;
        logic [17:0] expSeen;
    } vec_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        mdc      = 1'b0;
    logic        tbDrive  = 1'b0;
    logic        tbBit    = 1'b1;
    wire         mdio;
    logic [4:0]  regAddr;
    logic        regRe;
    logic        regWe;
    logic [15:0] regWdata;
    logic [15:0] regRdata = '0;
    logic        busy;
    logic        frameErr;

    logic [15:0] mem      [32];
    logic [15:0] modelMem [32];
    logic        tbLoad   = 1'b0;
    logic [4:0]  loadAddr = '0;
    logic [15:0] loadData = '0;

    int          checks     = 0;
    int          errors     = 0;
    int          reCycles   = 0;
    int          weCycles   = 0;
    int          errCycles  = 0;
    int          busyCycles = 0;
    int          reBase     = 0;
    int          weBase     = 0;
    int          errBase    = 0;
    int          busyBase   = 0;
    logic [4:0]  lastReAddr = '0;
    logic [4:0]  lastWeAddr = '0;
    logic [15:0] lastWeData = '0;
    int          halfPer    = 100;

    assign mdio = tbDrive ? tbBit : 1'bz;
    pullup (mdio);

    always #5 clk = ~clk;

    mdio_responder #(
        .PHY_ADDR    (PHY),
        .PREAMBLE_MIN(PRE_MIN),
        .TIMEOUT     (1000)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mdc_i      (mdc),
        .mdio_io    (mdio),
        .reg_addr_o (regAddr),
        .reg_re_o   (regRe),
        .reg_rdata_i(regRdata),
        .reg_we_o   (regWe),
        .reg_wdata_o(regWdata),
        .busy_o     (busy),
        .frame_err_o(frameErr)
    );

    // External register file: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (tbLoad) begin
            mem[loadAddr] <= loadData;
        end else if (regWe) begin
            mem[regAddr] <= regWdata;
        end
        if (regRe) begin
            regRdata <= mem[regAddr];
        end
    end

    always @(negedge clk) begin
        if (regRe) begin
            reCycles   <= reCycles + 1;
            lastReAddr <= regAddr;
        end
        if (regWe) begin
            weCycles   <= weCycles + 1;
            lastWeAddr <= regAddr;
            lastWeData <= regWdata;
        end
        if (frameErr) begin
            errCycles <= errCycles + 1;
        end
        if (busy) begin
            busyCycles <= busyCycles + 1;
        end
    end

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic mdcCycle(input logic drv, input logic val, output logic seen);
        tbDrive = drv;
        tbBit   = val;
        #(halfPer);
        seen = mdio;
        mdc  = 1'b1;
        #(halfPer);
        mdc  = 1'b0;
    endtask

    task automatic sendHeader(input vec_t v);
        logic s;
        for (int i = 0; i < v.preLen; i++) mdcCycle(1'b1, 1'b1, s);
        for (int i = 1; i >= 0; i--) mdcCycle(1'b1, v.st[i], s);
        for (int i = 1; i >= 0; i--) mdcCycle(1'b1, v.op[i], s);
        for (int i = 4; i >= 0; i--) mdcCycle(1'b1, v.phy[i], s);
        for (int i = 4; i >= 0; i--) mdcCycle(1'b1, v.regad[i], s);
    endtask

    task automatic snapshot();
        reBase   = reCycles;
        weBase   = weCycles;
        errBase  = errCycles;
        busyBase = busyCycles;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [17:0] seen);
        logic s;
        @(posedge clk);
        #2;
        snapshot();
        seen = '1;
        sendHeader(v);
        if (v.op[1]) begin
            for (int i = 17; i >= 0; i--) begin
                mdcCycle(1'b0, 1'b1, s);
                seen[i] = s;
            end
        end else begin
            mdcCycle(1'b1, 1'b1, s);
            mdcCycle(1'b1, 1'b0, s);
            for (int i = 15; i >= 0; i--) mdcCycle(1'b1, v.wdata[i], s);
        end
        tbDrive = 1'b0;
        #200;
    endtask

    task automatic checkOutput(input vec_t v, input logic [17:0] seen, input string tag);
        compare($sformatf("%s reCount", tag), reCycles - reBase, v.expRe);
        compare($sformatf("%s weCount", tag), weCycles - weBase, v.expWe);
        compare($sformatf("%s errCount", tag), errCycles - errBase, v.expErr);
        compare($sformatf("%s busySeen", tag), 32'((busyCycles - busyBase) > 0), 32'(v.expBusy));
        compare($sformatf("%s busyEnd", tag), 32'(busy), 32'd0);
        compare($sformatf("%s mdioIdle", tag), 32'(mdio), 32'd1);
        if (v.expRe != 0) begin
            compare($sformatf("%s reAddr", tag), 32'(lastReAddr), 32'(v.regad));
        end
        if (v.expWe != 0) begin
            compare($sformatf("%s weAddr", tag), 32'(lastWeAddr), 32'(v.regad));
            compare($sformatf("%s weData", tag), 32'(lastWeData), 32'(v.wdata));
            compare($sformatf("%s wdataHeld", tag), 32'(regWdata), 32'(v.wdata));
        end
        if (v.op[1]) begin
            compare($sformatf("%s mdioBits", tag), 32'(seen), 32'(v.expSeen));
        end
    endtask

    // Reference: outcome of a frame from its fields alone.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        logic preOk, startOk, opOk, hit;
        r       = v;
        preOk   = v.preLen >= PRE_MIN;
        startOk = preOk && (v.st == 2'b01);
        opOk    = (v.op == 2'b10) || (v.op == 2'b01);
        hit     = startOk && opOk && (v.phy == PHY);
        r.expBusy = startOk;
        r.expErr  = ((preOk && !startOk) || (startOk && !opOk)) ? 1 : 0;
        r.expRe   = (hit && v.op == 2'b10) ? 1 : 0;
        r.expWe   = (hit && v.op == 2'b01) ? 1 : 0;
        r.expSeen = (r.expRe != 0) ? {2'b10, modelMem[v.regad]} : '1;
        return r;
    endfunction

    initial begin
        vec_t        vecs [10];
        vec_t        v;
        logic [17:0] seen;
        logic        s;
        logic [15:0] val;
        int          r;

        vecs[0] = '{32, 2'b01, 2'b10, 5'd1,  5'd2,  16'h0000, 1, 0, 0, 1'b1, 18'h2A5C3};
        vecs[1] = '{32, 2'b01, 2'b01, 5'd1,  5'd3,  16'h1234, 0, 1, 0, 1'b1, 18'h3FFFF};
        vecs[2] = '{32, 2'b01, 2'b10, 5'd5,  5'd2,  16'h0000, 0, 0, 0, 1'b1, 18'h3FFFF};
        vecs[3] = '{32, 2'b01, 2'b10, 5'd1,  5'd3,  16'h0000, 1, 0, 0, 1'b1, 18'h21234};
        vecs[4] = '{31, 2'b01, 2'b10, 5'd1,  5'd2,  16'h0000, 0, 0, 0, 1'b0, 18'h3FFFF};
        vecs[5] = '{32, 2'b01, 2'b11, 5'd1,  5'd2,  16'h0000, 0, 0, 1, 1'b1, 18'h3FFFF};
        vecs[6] = '{32, 2'b00, 2'b10, 5'd1,  5'd2,  16'h0000, 0, 0, 1, 1'b0, 18'h3FFFF};
        vecs[7] = '{40, 2'b01, 2'b00, 5'd1,  5'd5,  16'h00FF, 0, 0, 1, 1'b1, 18'h3FFFF};
        vecs[8] = '{33, 2'b01, 2'b01, 5'd1,  5'd31, 16'hFFFF, 0, 1, 0, 1'b1, 18'h3FFFF};
        vecs[9] = '{32, 2'b01, 2'b10, 5'd1,  5'd31, 16'h0000, 1, 0, 0, 1'b1, 18'h2FFFF};

        #27;
        compare("reset regAddr", 32'(regAddr), 32'd0);
        compare("reset regRe", 32'(regRe), 32'd0);
        compare("reset regWe", 32'(regWe), 32'd0);
        compare("reset regWdata", 32'(regWdata), 32'd0);
        compare("reset busy", 32'(busy), 32'd0);
        compare("reset frameErr", 32'(frameErr), 32'd0);
        compare("reset mdio", 32'(mdio), 32'd1);

        for (int i = 0; i < 32; i++) begin
            val = (i == 2) ? 16'hA5C3 : (i == 9) ? 16'h0000 : 16'($urandom);
            modelMem[i] = val;
            tbLoad   = 1'b1;
            loadAddr = 5'(i);
            loadData = val;
            @(posedge clk);
            #2;
        end
        tbLoad = 1'b0;
        rst    = 1'b0;
        #20;

        for (int i = 0; i < 10; i++) begin
            halfPer = (i == 0) ? 200 : 100;
            applyStimulus(vecs[i], seen);
            checkOutput(vecs[i], seen, $sformatf("vec%0d", i));
            if (vecs[i].expWe != 0) modelMem[vecs[i].regad] = vecs[i].wdata;
        end
        halfPer = 100;

        // Reset while the responder is driving the ninth data bit of a read.
        v = predict('{32, 2'b01, 2'b10, 5'd1, 5'd9, 16'h0000, 0, 0, 0, 1'b0, '0});
        @(posedge clk);
        #2;
        snapshot();
        sendHeader(v);
        for (int i = 0; i < 10; i++) mdcCycle(1'b0, 1'b1, s);
        #40;
        compare("rstMid drivenLow", 32'(mdio), 32'd0);
        compare("rstMid busyBefore", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        compare("rstMid mdioReleased", 32'(mdio), 32'd1);
        compare("rstMid regAddr", 32'(regAddr), 32'd0);
        compare("rstMid regWdata", 32'(regWdata), 32'd0);
        compare("rstMid busy", 32'(busy), 32'd0);
        compare("rstMid regRe", 32'(regRe), 32'd0);
        compare("rstMid regWe", 32'(regWe), 32'd0);
        compare("rstMid frameErr", 32'(frameErr), 32'd0);
        #29;
        rst = 1'b0;
        #20;
        compare("rstMid reCount", reCycles - reBase, 32'd1);
        compare("rstMid errCount", errCycles - errBase, 32'd0);

        // MDC stalls partway through the write data.
        v = '{32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hBEEF, 0, 0, 0, 1'b0, '0};
        @(posedge clk);
        #2;
        snapshot();
        sendHeader(v);
        mdcCycle(1'b1, 1'b1, s);
        mdcCycle(1'b1, 1'b0, s);
        for (int i = 15; i >= 11; i--) mdcCycle(1'b1, v.wdata[i], s);
        tbDrive = 1'b0;
        #100;
        compare("stall busyBefore", 32'(busy), 32'd1);
        #11000;
        compare("stall errCount", errCycles - errBase, 32'd1);
        compare("stall weCount", weCycles - weBase, 32'd0);
        compare("stall busy", 32'(busy), 32'd0);

        v = predict('{32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 0, 0, 0, 1'b0, '0});
        applyStimulus(v, seen);
        checkOutput(v, seen, "afterStall");

        for (int n = 0; n < 16; n++) begin
            v.preLen = 32 + int'($urandom_range(0, 4));
            v.st     = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
            r        = int'($urandom_range(0, 9));
            v.op     = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
            v.phy    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            v.regad  = 5'($urandom);
            v.wdata  = 16'($urandom);
            v        = predict(v);
            applyStimulus(v, seen);
            checkOutput(v, seen, $sformatf("rand%0d", n));
            if (v.expWe != 0) modelMem[v.regad] = v.wdata;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
